wb_seq_master: RTL

Wishbone initiator that runs sequential single-beat word transfers against the user-project Wishbone slave (the SDRAM controller front end). It accepts a command of base address, word count and direction, then drives classic Wishbone read or write cycles with the address incrementing by 4. Write data arrives on a valid/ready stream; read data leaves through an internal FIFO on a valid/ready stream. It serves as the bench and on-chip traffic source for exercising the SDRAM path, including its sequential-address prefetch.

---
 rtl/wb_seq_master.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_seq_master.sv
`default_nettype none
// ============================================================================
//  Module   : wb_seq_master
//  Purpose  : Wishbone initiator issuing sequential single-beat word reads or
//             writes from a base address, with a streamed write source and a
//             read-data FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_seq_master #(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   // command
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_addr,
   input  logic [7:0]  cmd_len,
   // write-data stream
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_data,
   // read-data stream
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [31:0] rd_data,
   // status
   output logic        busy,
   output logic        done,
   output logic        err,
   // Wishbone initiator
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   localparam int          c_AW       = $clog2(FIFO_DEPTH);
   localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_BUS   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [31:0] r_addr;
   logic        r_we;
   logic [7:0]  r_remain;
   logic [15:0] r_tmo;
   logic        r_err;
   logic [31:0] r_adr_o;
   logic [31:0] r_dat_o;

   logic [31:0]     r_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_wptr;
   logic [c_AW-1:0] r_rptr;
   logic [c_AW:0]   r_count;

   logic w_cyc;
   logic w_accept;
   logic w_fifo_full;
   logic w_ack;
   logic w_tmo;
   logic w_push;
   logic w_pop;

   // Count never exceeds FIFO_DEPTH, so its top bit alone marks full.
   assign w_fifo_full = r_count[c_AW];
   assign w_ack       = w_cyc & wbm_ack_i;
   assign w_tmo       = w_cyc & ~wbm_ack_i & (r_tmo == c_TMO_LAST);
   assign w_push      = w_ack & ~r_we;
   assign w_pop       = rd_valid & rd_ready;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_cyc     = 1'b0;
      w_accept  = 1'b0;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      wr_ready  = 1'b0;
      wbm_sel_o = 4'h0;
      wbm_we_o  = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               w_accept = 1'b1;
               w_next   = (cmd_len == 8'd0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            // A read only launches with a free FIFO slot, so a push never hits a full FIFO.
            if (r_we) begin
               wr_ready = 1'b1;
               if (wr_valid) begin
                  w_next = S_BUS;
               end
            end else if (!w_fifo_full) begin
               w_next = S_BUS;
            end
         end
         S_BUS: begin
            w_cyc     = 1'b1;
            wbm_sel_o = 4'hF;
            wbm_we_o  = r_we;
            if (wbm_ack_i) begin
               w_next = (r_remain == 8'd1) ? S_DONE : S_FETCH;
            end else if (r_tmo == c_TMO_LAST) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_addr   <= 32'd0;
         r_we     <= 1'b0;
         r_remain <= 8'd0;
         r_tmo    <= 16'd0;
         r_err    <= 1'b0;
         r_adr_o  <= 32'd0;
         r_dat_o  <= 32'd0;
      end else begin
         if (w_accept) begin
            r_addr   <= cmd_addr & 32'hFFFF_FFFC;
            r_we     <= cmd_we;
            r_remain <= cmd_len;
            r_err    <= 1'b0;
         end
         if (r_state == S_FETCH && w_next == S_BUS) begin
            r_adr_o <= r_addr;
            r_tmo   <= 16'd0;
            if (r_we) begin
               r_dat_o <= wr_data;
            end
         end
         if (w_ack) begin
            r_addr   <= r_addr + 32'd4;
            r_remain <= r_remain - 8'd1;
         end else if (w_cyc) begin
            r_tmo <= r_tmo + 16'd1;
         end
         if (w_tmo) begin
            r_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= wbm_dat_i;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign rd_valid  = (r_count != '0);
   assign rd_data   = r_mem[r_rptr];
   assign err       = r_err;
   assign wbm_cyc_o = w_cyc;
   assign wbm_stb_o = w_cyc;
   assign wbm_adr_o = r_adr_o;
   assign wbm_dat_o = r_dat_o;

endmodule
`default_nettype wire
